// File: rtl/muldiv_seq_if.sv
// EX <-> mult/div sequencer handshake and HI/LO write-back bundle.
// The master (EX/pipeline side) issues requests; the slave (sequencer) returns stall and results.
interface muldiv_seq_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [1:0]       md_op;
   logic [WIDTH-1:0] regaData;
   logic [WIDTH-1:0] regbData;
   logic             cancel;
   logic             stall;
   logic             busy;
   logic             whi;
   logic             wlo;
   logic [WIDTH-1:0] wHiData;
   logic [WIDTH-1:0] wLoData;
   logic             div_zero;

   modport master (
      output start, md_op, regaData, regbData, cancel,
      input  stall, busy, whi, wlo, wHiData, wLoData, div_zero
   );

   modport slave (
      input  start, md_op, regaData, regbData, cancel,
      output stall, busy, whi, wlo, wHiData, wLoData, div_zero
   );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle mult/multu/div/divu sequencer: magnitude shift-add multiply or restoring divide,
// one iteration per cycle, sign fix-up on the last iteration, one-cycle HI/LO write pulse.
module muldiv_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ITER  = 32
) (
   input  logic        clk,
   input  logic        rst,
   muldiv_seq_if.slave md
);
   typedef enum logic [1:0] {IDLE, PREP, RUN, DONE} state_t;

   state_t               r_state;
   logic [1:0]           r_op;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic                 r_dz;
   logic                 r_wr;
   logic [5:0]           r_cnt;
   logic [2*WIDTH-1:0]   r_acc;

   logic                 w_signed;
   logic                 w_div;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic [WIDTH:0]       w_sum;
   logic [WIDTH:0]       w_trial;
   logic [2*WIDTH-1:0]   w_acc_nx;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_quo;
   logic [WIDTH-1:0]     w_rem;

   assign w_signed = ~r_op[0];
   assign w_div    = r_op[1];
   assign w_a_mag  = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
   assign w_b_mag  = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

   // r_acc is {partial product, multiplier} for mult and {remainder, quotient} for div;
   // after PREP, r_a holds |multiplicand| and r_b holds |divisor|.
   always_comb begin
      w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
      w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
      if (w_div) begin
         if (!w_trial[WIDTH]) w_acc_nx = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
         else                 w_acc_nx = {r_acc[2*WIDTH-2:0], 1'b0};
      end else if (r_acc[0]) begin
         w_acc_nx = {w_sum, r_acc[WIDTH-1:1]};
      end else begin
         w_acc_nx = {1'b0, r_acc[2*WIDTH-1:1]};
      end
      w_prod = r_neg_q ? -w_acc_nx : w_acc_nx;
      w_quo  = r_neg_q ? -w_acc_nx[WIDTH-1:0] : w_acc_nx[WIDTH-1:0];
      w_rem  = r_neg_r ? -w_acc_nx[2*WIDTH-1:WIDTH] : w_acc_nx[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
         r_wr    <= 1'b0;
         r_cnt   <= '0;
         r_acc   <= '0;
      end else begin
         r_wr <= 1'b0;
         r_dz <= 1'b0;
         if (md.cancel) begin
            r_state <= IDLE;
         end else begin
            case (r_state)
               IDLE: if (md.start) begin
                  r_op    <= md.md_op;
                  r_a     <= md.regaData;
                  r_b     <= md.regbData;
                  r_state <= PREP;
               end
               PREP: begin
                  r_neg_q <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                  r_neg_r <= w_signed & r_a[WIDTH-1];
                  r_a     <= w_a_mag;
                  r_b     <= w_b_mag;
                  r_cnt   <= '0;
                  if (w_div && r_b == '0) begin
                     r_hi    <= r_a;
                     r_lo    <= '1;
                     r_dz    <= 1'b1;
                     r_wr    <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_acc   <= w_div ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
                     r_state <= RUN;
                  end
               end
               RUN: begin
                  r_acc <= w_acc_nx;
                  r_cnt <= r_cnt + 6'd1;
                  if (r_cnt == 6'(ITER - 1)) begin
                     r_hi    <= w_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
                     r_lo    <= w_div ? w_quo : w_prod[WIDTH-1:0];
                     r_wr    <= 1'b1;
                     r_state <= DONE;
                  end
               end
               DONE:    r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign md.stall    = ~rst & ((r_state == IDLE && md.start && !md.cancel) ||
                                r_state == PREP || r_state == RUN);
   assign md.busy     = (r_state != IDLE);
   assign md.whi      = r_wr;
   assign md.wlo      = r_wr;
   assign md.div_zero = r_dz;
   assign md.wHiData  = r_hi;
   assign md.wLoData  = r_lo;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: a latency/arithmetic reference model checked every cycle,
// plus hand-computed literal results, cancel, reset and back-to-back scenarios.
module tb_muldiv_seq;
   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   muldiv_seq_if #(.WIDTH(W)) md ();
   muldiv_seq #(.WIDTH(W), .ITER(W)) dut (.clk(clk), .rst(rst), .md(md));

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   // Reference state: active op, acceptance cycle, pulse cycle, expected {dz,hi,lo}, held data.
   logic        m_act = 1'b0;
   int          m_pulse = 0;
   logic [64:0] m_exp = '0;
   logic [63:0] m_hold = '0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
   endtask

   function automatic logic [64:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin p = 64'(sa * sb); return {1'b0, p}; end
         2'b01: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
         default: begin
            if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
            if (op == 2'b10) begin
               q = sa / sb;
               r = sa % sb;
               return {1'b0, r[31:0], q[31:0]};
            end
            return {1'b0, a % b, a / b};
         end
      endcase
   endfunction

   always @(posedge clk) begin
      if (m_act && cyc == m_pulse && !rst) m_hold = m_exp[63:0];
      if (rst) begin
         m_act  = 1'b0;
         m_hold = '0;
      end else if (md.cancel) begin
         m_act = 1'b0;
      end else if (m_act && cyc == m_pulse) begin
         m_act = 1'b0;
      end else if (!m_act && md.start) begin
         m_act   = 1'b1;
         m_exp   = ref_op(md.md_op, md.regaData, md.regbData);
         m_pulse = cyc + ((md.md_op[1] && md.regbData == 0) ? 2 : 34);
      end
      cyc++;
   end

   always @(negedge clk) begin
      logic e_pulse, e_stall;
      if (cyc > 0) begin
         e_pulse = m_act && (cyc == m_pulse);
         e_stall = !rst && ((m_act && cyc < m_pulse) || (!m_act && md.start && !md.cancel));
         check("stall", md.stall, e_stall);
         check("busy", md.busy, m_act);
         check("whi", md.whi, e_pulse);
         check("wlo", md.wlo, e_pulse);
         check("div_zero", md.div_zero, e_pulse & m_exp[64]);
         check("wHiData", md.wHiData, e_pulse ? m_exp[63:32] : m_hold[63:32]);
         check("wLoData", md.wLoData, e_pulse ? m_exp[31:0] : m_hold[31:0]);
      end
   end

   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo,
                         input logic e_dz, input int lat);
      int t0;
      bit got;
      got = 1'b0;
      @(posedge clk); #2;
      md.start = 1'b1; md.md_op = op; md.regaData = a; md.regbData = b;
      t0 = cyc;
      @(posedge clk); #2;
      md.start = 1'b0; md.regaData = ~a; md.regbData = ~b;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (md.whi) got = 1'b1;
      end
      check({name, " latency"}, got ? (cyc - t0) : -1, lat);
      if (got) begin
         check({name, " HI"}, md.wHiData, e_hi);
         check({name, " LO"}, md.wLoData, e_lo);
         check({name, " div_zero"}, md.div_zero, e_dz);
      end
      @(negedge clk);
      check({name, " busy after"}, md.busy, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, np, c1, c2, nw;
      logic [31:0] h1, l1, h2, l2;
      md.start = 1'b0; md.md_op = 2'b00; md.regaData = '0; md.regbData = '0; md.cancel = 1'b0;

      check("model div -7/2", ref_op(2'b10, 32'hFFFF_FFF9, 32'd2), {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
      check("model mult -3*7", ref_op(2'b00, 32'hFFFF_FFFD, 32'd7), {1'b0, 64'hFFFF_FFFF_FFFF_FFEB});
      check("model div ovf", ref_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), {1'b0, 64'h0000_0000_8000_0000});

      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("reset busy", md.busy, 1'b0);
      check("reset whi", md.whi, 1'b0);
      check("reset HI", md.wHiData, 32'h0);
      check("reset LO", md.wLoData, 32'h0);

      run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
      run_op("mult -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
      run_op("mult minint^2", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 34);
      run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
      run_op("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34);
      run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
      run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34);
      run_op("divu by 0", 2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 2);

      // Cancel at relative cycle 10 of a multu.
      @(posedge clk); #2;
      md.start = 1'b1; md.md_op = 2'b01; md.regaData = 32'd5; md.regbData = 32'd6;
      t0 = cyc;
      @(posedge clk); #2;
      md.start = 1'b0;
      repeat (9) @(posedge clk);
      #2 md.cancel = 1'b1;
      @(posedge clk);
      #2 md.cancel = 1'b0;
      @(negedge clk);
      check("cancel cycle", cyc - t0, 11);
      check("cancel busy", md.busy, 1'b0);
      check("cancel stall", md.stall, 1'b0);
      check("cancel LO held", md.wLoData, 32'hFFFF_FFFF);
      nw = 0;
      repeat (30) begin
         @(negedge clk);
         if (md.whi || md.wlo) nw++;
      end
      check("cancel no pulse", nw, 0);

      // Reset at relative cycle 20 of a signed divide.
      @(posedge clk); #2;
      md.start = 1'b1; md.md_op = 2'b10; md.regaData = 32'hFFFF_FFF9; md.regbData = 32'd2;
      @(posedge clk); #2;
      md.start = 1'b0;
      repeat (19) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("rst busy", md.busy, 1'b0);
      check("rst whi", md.whi, 1'b0);
      check("rst HI", md.wHiData, 32'h0);
      check("rst LO", md.wLoData, 32'h0);

      // start held through DONE: one pulse at 34, second accept at 35 pulses at 69.
      np = 0; c1 = -1; c2 = -1; h1 = '0; l1 = '0; h2 = '0; l2 = '0;
      @(posedge clk); #2;
      md.start = 1'b1; md.md_op = 2'b11; md.regaData = 32'd100; md.regbData = 32'd7;
      for (int k = 1; k <= 75; k++) begin
         @(posedge clk); #2;
         if (k == 1) begin md.regaData = 32'd1000; md.regbData = 32'd9; end
         if (k == 36) md.start = 1'b0;
         @(negedge clk);
         if (md.whi) begin
            if (np == 0) begin c1 = k; h1 = md.wHiData; l1 = md.wLoData; end
            else begin c2 = k; h2 = md.wHiData; l2 = md.wLoData; end
            np++;
         end
      end
      check("b2b pulse count", np, 2);
      check("b2b first cycle", c1, 34);
      check("b2b second cycle", c2, 69);
      check("b2b first LO", l1, 32'd14);
      check("b2b first HI", h1, 32'd2);
      check("b2b second LO", l2, 32'd111);
      check("b2b second HI", h2, 32'd1);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
